// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a 16-entry single-port RAM with registered, gated read data.
// The RAM supplies storage; a one-entry output register adds a 17th slot.
module ram_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4:0]            level,
   output logic                  full,
   output logic                  empty,
   output logic                  ram_cs,
   output logic                  ram_wr_en,
   output logic                  ram_out_en,
   output logic [3:0]            ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH:0]   ram_rdata
);

   localparam logic [4:0] FULL_CNT = 5'(DEPTH);

   typedef enum logic {IDLE, RD_CAP} state_t;

   state_t     state, state_nxt;
   logic [3:0] wr_ptr, rd_ptr;
   logic [4:0] ram_count;
   logic       rd_go, push, pop;
   logic       rdata_msb_unused;

   assign rdata_msb_unused = ram_rdata[DATA_WIDTH];
   assign ram_wdata        = in_data;
   assign pop              = out_valid && out_ready;
   assign level            = ram_count + {4'b0, out_valid};
   assign full             = (ram_count == FULL_CNT);
   assign empty            = (level == 5'd0);

   // Read has priority: a read is issued whenever the output register is free or being drained.
   always_comb begin
      state_nxt  = state;
      ram_cs     = 1'b0;
      ram_wr_en  = 1'b0;
      ram_out_en = 1'b0;
      ram_addr   = wr_ptr;
      in_ready   = 1'b0;
      push       = 1'b0;
      rd_go      = (ram_count != 5'd0) && (!out_valid || out_ready);
      case (state)
         IDLE: begin
            if (rd_go) begin
               ram_cs    = 1'b1;
               ram_addr  = rd_ptr;
               state_nxt = RD_CAP;
            end else begin
               in_ready = (ram_count < FULL_CNT);
               push     = in_valid && in_ready;
               if (push) begin
                  ram_cs    = 1'b1;
                  ram_wr_en = 1'b1;
               end
            end
         end
         RD_CAP: begin
            ram_cs     = 1'b1;
            ram_out_en = 1'b1;
            ram_addr   = rd_ptr;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wr_ptr    <= 4'd0;
         rd_ptr    <= 4'd0;
         ram_count <= 5'd0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         state <= state_nxt;
         if (push) begin
            wr_ptr    <= wr_ptr + 4'd1;
            ram_count <= ram_count + 5'd1;
         end
         // RAM output is only driven in RD_CAP, so that is the one cycle it is sampled.
         if (state == RD_CAP) begin
            out_data  <= ram_rdata[DATA_WIDTH-1:0];
            out_valid <= 1'b1;
            rd_ptr    <= rd_ptr + 4'd1;
            ram_count <= ram_count - 5'd1;
         end else if (pop) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM, queue scoreboard, and per-scenario tasks.
// Undriven RAM output is modelled as random junk so any sampling outside RD_CAP corrupts data.
module tb_ram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] level;
   logic       full;
   logic       empty;
   logic       ram_cs;
   logic       ram_wr_en;
   logic       ram_out_en;
   logic [3:0] ram_addr;
   logic [7:0] ram_wdata;
   logic [8:0] ram_rdata;

   int tests = 0;
   int fails = 0;

   ram_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .level(level), .full(full), .empty(empty),
      .ram_cs(ram_cs), .ram_wr_en(ram_wr_en), .ram_out_en(ram_out_en),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // RAM model: synchronous write, registered read, gated output.
   logic [7:0] mem [16];
   logic [7:0] rq;
   logic [8:0] junk;
   always @(posedge clk) begin
      junk <= 9'($urandom);
      if (ram_cs && ram_wr_en) mem[ram_addr] <= ram_wdata;
      if (ram_cs && !ram_wr_en) rq <= mem[ram_addr];
   end
   always_comb ram_rdata = ram_out_en ? {junk[8], rq} : junk;

   // Scoreboard: FIFO order, occupancy and RAM access rules, sampled mid-cycle.
   logic [7:0] model_q [$];
   int   wr_cnt, rd_cnt;
   logic [3:0] last_wr, last_rd;
   logic wr_wrap, rd_wrap;
   always @(negedge clk) begin
      if (!rst_n) begin
         model_q.delete();
         wr_cnt = 0; rd_cnt = 0; last_wr = 4'd0; last_rd = 4'd0;
      end else begin
         tests++;
         if (level !== 5'(model_q.size())) begin
            fails++; $display("FAIL mon_level: got %0d expected %0d", level, model_q.size());
         end
         tests++;
         if (empty !== (model_q.size() == 0)) begin
            fails++; $display("FAIL mon_empty: got %0b expected %0b", empty, model_q.size() == 0);
         end
         tests++;
         if (ram_out_en && ram_wr_en) begin
            fails++; $display("FAIL mon_contention: write enabled during read capture");
         end
         tests++;
         if (ram_cs && !ram_wr_en && !ram_out_en && in_ready) begin
            fails++; $display("FAIL mon_rd_issue_ready: in_ready=1 on read issue");
         end
         tests++;
         if (in_ready && (model_q.size() - int'(out_valid)) >= 16) begin
            fails++; $display("FAIL mon_overfill: in_ready=1 with RAM holding %0d", model_q.size() - int'(out_valid));
         end
         if (ram_cs && ram_wr_en) begin
            tests++;
            if (ram_addr !== wr_cnt[3:0] || !(in_valid && in_ready)) begin
               fails++; $display("FAIL mon_write: addr %0d expected %0d push=%0b", ram_addr, wr_cnt[3:0], in_valid && in_ready);
            end
            if (ram_addr == 4'd0 && last_wr == 4'd15) wr_wrap = 1'b1;
            last_wr = ram_addr;
            wr_cnt++;
         end
         if (ram_out_en) begin
            tests++;
            if (ram_addr !== rd_cnt[3:0]) begin
               fails++; $display("FAIL mon_read_addr: got %0d expected %0d", ram_addr, rd_cnt[3:0]);
            end
            if (ram_addr == 4'd0 && last_rd == 4'd15) rd_wrap = 1'b1;
            last_rd = ram_addr;
            rd_cnt++;
         end
         if (out_valid && out_ready) begin
            tests++;
            if (model_q.size() == 0) begin
               fails++; $display("FAIL mon_pop: got %02h expected no data", out_data);
            end else begin
               if (out_data !== model_q[0]) begin
                  fails++; $display("FAIL mon_pop: got %02h expected %02h", out_data, model_q[0]);
               end
               void'(model_q.pop_front());
            end
         end
         if (in_valid && in_ready) model_q.push_back(in_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
      repeat (2) tick();
      tests++;
      if ({out_valid, level, empty, ram_cs} !== {1'b0, 5'd0, 1'b1, 1'b0}) begin
         fails++; $display("FAIL reset_init: ov=%0b lvl=%0d empty=%0b cs=%0b required 0/0/1/0", out_valid, level, empty, ram_cs);
      end
      rst_n = 1'b1;
      tick();
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 8'($urandom);
         tick();
      end
      in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      tests++;
      if ({out_valid, level, empty, ram_cs} !== {1'b0, 5'd0, 1'b1, 1'b0}) begin
         fails++; $display("FAIL reset_async: ov=%0b lvl=%0d empty=%0b cs=%0b required 0/0/1/0", out_valid, level, empty, ram_cs);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      in_data = 8'hA5; in_valid = 1'b1; out_ready = 1'b0;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++; $display("FAIL single_ready: in_ready=%0b required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      #1;
      tests++;
      if ({ram_cs, ram_wr_en, ram_out_en, in_ready} !== 4'b1000) begin
         fails++; $display("FAIL single_rd_issue: cs/we/oe/ready=%04b required 1000", {ram_cs, ram_wr_en, ram_out_en, in_ready});
      end
      tick();
      tests++;
      if ({ram_out_en, ram_addr, out_valid} !== {1'b1, 4'd0, 1'b0}) begin
         fails++; $display("FAIL single_rd_cap: oe=%0b addr=%0d ov=%0b required 1/0/0", ram_out_en, ram_addr, out_valid);
      end
      tick();
      tests++;
      if ({out_valid, out_data} !== {1'b1, 8'hA5}) begin
         fails++; $display("FAIL single_out: ov=%0b data=%02h required 1/a5", out_valid, out_data);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      tests++;
      if ({out_valid, empty} !== 2'b01) begin
         fails++; $display("FAIL single_pop: ov=%0b empty=%0b required 0/1", out_valid, empty);
      end
   endtask

   task automatic test_fill();
      logic [7:0] val = 8'h01;
      int acc = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 40; c++) begin
         in_data = val; in_valid = 1'b1;
         #1;
         if (in_ready) begin
            acc++; val++;
         end
         tick();
      end
      #1;
      tests++;
      if (acc !== 17) begin
         fails++; $display("FAIL fill_accepted: got %0d required 17", acc);
      end
      tests++;
      if ({level, full, in_ready} !== {5'd17, 1'b1, 1'b0}) begin
         fails++; $display("FAIL fill_state: lvl=%0d full=%0b ready=%0b required 17/1/0", level, full, in_ready);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 100 && !empty; c++) tick();
      out_ready = 1'b0;
      tests++;
      if ({empty, level} !== {1'b1, 5'd0}) begin
         fails++; $display("FAIL fill_drain: empty=%0b lvl=%0d required 1/0", empty, level);
      end
   endtask

   task automatic test_wrap();
      int pushed = 0, popped = 0, cyc = 0;
      wr_wrap = 1'b0; rd_wrap = 1'b0;
      while ((pushed < 40 || popped < 40) && cyc < 3000) begin
         in_valid  = (pushed < 40) && ($urandom_range(0, 3) != 0);
         in_data   = 8'(pushed);
         out_ready = 1'($urandom_range(0, 1));
         #1;
         if (in_valid && in_ready) pushed++;
         if (out_valid && out_ready) popped++;
         tick();
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      tests++;
      if (popped !== 40 || pushed !== 40) begin
         fails++; $display("FAIL wrap_count: pushed %0d popped %0d required 40/40", pushed, popped);
      end
      tests++;
      if ({wr_wrap, rd_wrap} !== 2'b11) begin
         fails++; $display("FAIL wrap_ptr: wr_wrap=%0b rd_wrap=%0b required 1/1", wr_wrap, rd_wrap);
      end
      tests++;
      if (empty !== 1'b1) begin
         fails++; $display("FAIL wrap_empty: empty=%0b required 1", empty);
      end
   endtask

   task automatic test_back_to_back();
      int pushes = 0, pops = 0, viol = 0;
      logic [7:0] val = 8'h80;
      out_ready = 1'b1;
      for (int c = 0; c < 120; c++) begin
         in_data = val; in_valid = 1'b1;
         #1;
         if (ram_out_en && ram_wr_en) viol++;
         if (ram_cs && !ram_wr_en && !ram_out_en && in_ready) viol++;
         if (in_ready) begin
            pushes++; val++;
         end
         if (out_valid) pops++;
         tick();
      end
      in_valid = 1'b0;
      for (int c = 0; c < 50 && !empty; c++) begin
         if (out_valid) pops++;
         tick();
      end
      out_ready = 1'b0;
      tests++;
      if (viol !== 0) begin
         fails++; $display("FAIL b2b_rules: %0d violations required 0", viol);
      end
      tests++;
      if (pops !== pushes || pushes == 0 || level !== 5'd0) begin
         fails++; $display("FAIL b2b_conserve: pushes %0d pops %0d lvl %0d required equal, nonzero, 0", pushes, pops, level);
      end
   endtask

   task automatic test_mid_read_reset();
      int waited = 0;
      out_ready = 1'b0; in_data = 8'h77; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tests++;
      if (ram_out_en !== 1'b1) begin
         fails++; $display("FAIL mrr_in_rdcap: oe=%0b required 1", ram_out_en);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if ({ram_cs, out_valid, level} !== {1'b0, 1'b0, 5'd0}) begin
         fails++; $display("FAIL mrr_abort: cs=%0b ov=%0b lvl=%0d required 0/0/0", ram_cs, out_valid, level);
      end
      tick();
      rst_n = 1'b1;
      tick();
      tests++;
      if ({level, empty} !== {5'd0, 1'b1}) begin
         fails++; $display("FAIL mrr_after: lvl=%0d empty=%0b required 0/1", level, empty);
      end
      in_data = 8'h3C; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      while (!out_valid && waited < 10) begin
         tick();
         waited++;
      end
      tests++;
      if ({out_valid, out_data} !== {1'b1, 8'h3C}) begin
         fails++; $display("FAIL mrr_data: ov=%0b data=%02h required 1/3c", out_valid, out_data);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
      wr_wrap = 1'b0; rd_wrap = 1'b0;
      test_reset();
      test_single();
      test_fill();
      test_wrap();
      test_back_to_back();
      test_mid_read_reset();
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
